adder_host_master: RTL and testbench
====================================

Name: adder_host_master

Overview:
Initiator-side companion to the 8-bit adder datapath (dut_8bit_addr). It buffers host operand pairs and issues them on the adder's Value_a/Value_b/Data_val interface. It captures Sum_result/Sum_carry when Data_ready is high and returns 9-bit results to the host. It also masters the adder's Des_* configuration register port, running single read/write transactions on host request.

Parameters:
FIFO_DEPTH, 4, operand FIFO entries (power of 2, ≥2)
RD_LATENCY, 1, cycles from the Des_req_valid cycle to valid Des_rd_value (1..7)

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
op_valid  in  1  host operand pair valid
op_ready  out  1  FIFO not full
op_a  in  8  operand A
op_b  in  8  operand B
res_valid  out  1  one-cycle result pulse
res_data  out  9  {carry, sum}
err_stray  out  1  sticky: Data_ready seen with nothing pending
pending  out  4  issued-but-unanswered operand count
reg_req  in  1  register transaction request (sampled only when reg_busy=0)
reg_wr  in  1  1=write, 0=read
reg_addr  in  3  register address
reg_wdata  in  8  write data
reg_busy  out  1  FSM not IDLE
reg_done  out  1  one-cycle completion pulse
reg_rdata  out  8  read data, valid with reg_done on reads, held afterwards
Value_a  out  8  to adder
Value_b  out  8  to adder
Data_val  out  1  operand strobe to adder
Sum_result  in  8  from adder
Sum_carry  in  1  from adder
Data_ready  in  1  from adder
Des_address  out  3  register address to adder
Des_value  out  8  register write data
Des_req_valid  out  1  register request strobe
Des_wr_rd  out  1  1=write, 0=read
Des_rd_value  in  8  register read data

Behaviour:
- Reset (async, reset_n=0): all outputs 0, except op_ready=1. FIFO is emptied, pending=0, err_stray=0, FSM=IDLE. Reset mid-transaction abandons the transaction; no reg_done is issued.
- Operand push: on edge where op_valid&op_ready. op_ready=0 when FIFO holds FIFO_DEPTH entries. No same-cycle bypass when full.
- Issue: on an edge where FIFO is non-empty, FSM=IDLE, and no reg_req is being accepted, pop one entry.
  - Value_a/Value_b load the entry and Data_val=1 for exactly that next cycle.
  - Value_a/Value_b hold their last values while Data_val=0.
  - Minimum latency: push edge N → Data_val high in cycle after edge N+1. Back-to-back issue is one per cycle.
- Priority: reg_req in IDLE beats operand issue. Operand issue is stalled for the whole register transaction, including the cycle Des_req_valid is high.
- Result capture: Data_ready sampled at edge → res_valid=1 and res_data={Sum_carry,Sum_result} in the following cycle (1-cycle latency, no backpressure).
- pending: +1 per issue, −1 per Data_ready. Net 0 when both occur on the same edge. Saturates at 15 and does not wrap below 0. Data_ready with pending=0 sets err_stray, which is cleared only by reset.
- FSM IDLE → REQ on reg_req accepted; address, data and direction are latched.
- FSM REQ (1 cycle): Des_req_valid=1 with Des_address/Des_value/Des_wr_rd driven. Des_value=0 on reads. Des_* outputs are 0 outside REQ.
  - Write: REQ → DONE.
  - Read: REQ → WAIT.
- FSM WAIT: counts RD_LATENCY−1 further cycles (with RD_LATENCY=1, WAIT lasts 1 cycle). Des_rd_value is sampled into reg_rdata on the edge ending the cycle RD_LATENCY cycles after REQ. Then → DONE.
- FSM DONE (1 cycle): reg_done=1 → IDLE. reg_req is not accepted in DONE; it is accepted the following cycle at the earliest.
- Write turnaround: request edge → REQ cycle → DONE cycle, so 3 cycles from request to a new request.

Decomposition:
- Shared package adder_host_pkg: FSM state enum (IDLE, REQ, WAIT, DONE), DES_WR=1 / DES_RD=0, OPERAND_W=8, DES_ADDR_W=3, RESULT_W=9.
- One sub-module, adder_op_fifo: synchronous FIFO with push/pop/full/empty, parameterized by FIFO_DEPTH. The register FSM, issue logic and result capture stay in the top.

Test Plan:
- Push A1/C2, adder model answers Data_ready one cycle after Data_val → Data_val single pulse with Value_a=A1, Value_b=C2; res_valid pulse with res_data=9'h163; pending 0→1→0.
- Push D1/35, 05/38, 55/38, AA/AA on consecutive cycles → four consecutive Data_val cycles in order; results 9'h106, 9'h03D, 9'h08D, 9'h154.
- With RD_LATENCY=4: read addr 2 (model returns 3C), then push 5 operands → Data_val stays 0 during the transaction; op_ready falls after 4 pushes; reg_rdata=3C with reg_done; FIFO then drains in order.
- Write addr 3 data 5A → Des_req_valid one cycle with Des_address=3, Des_value=5A, Des_wr_rd=1; reg_done next cycle; second reg_req accepted no earlier than 3 cycles after the first.
- Data_ready pulse with pending=0 → err_stray=1 and remains 1; res_valid still pulses.
- Assert reset_n=0 during WAIT with 2 FIFO entries → all outputs 0 immediately (op_ready=1); after release, no reg_done and no Data_val until a new push.

Source files
------------

// File: rtl/adder_host_pkg.sv
// Shared types and widths for the adder host master and its operand FIFO.
package adder_host_pkg;

    localparam int unsigned OPERAND_W  = 8;
    localparam int unsigned DES_ADDR_W = 3;
    localparam int unsigned RESULT_W   = 9;
    localparam int unsigned PENDING_W  = 4;
    localparam int unsigned LAT_W      = 3;

    localparam logic DES_WR = 1'b1;
    localparam logic DES_RD = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } reg_state_e;

    typedef struct packed {
        logic [OPERAND_W-1:0] a;
        logic [OPERAND_W-1:0] b;
    } op_pair_t;

endpackage

// File: rtl/adder_op_fifo.sv
// Synchronous operand-pair FIFO; head entry is visible combinationally.
module adder_op_fifo
    import adder_host_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
)
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  op_pair_t push_data,
    input  logic     pop,
    output op_pair_t head_c,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    op_pair_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    // Qualify push/pop with occupancy and compute the next fill level.
    always_comb begin
        do_push    = push && !full;
        do_pop     = pop && !empty;
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Pointers, fill level and registered full/empty flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == CNT_W'(FIFO_DEPTH));
            empty <= (count_next == CNT_W'(0));
        end
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_c = mem[rd_ptr];

endmodule

// File: rtl/adder_host_master.sv
// Initiator for the 8-bit adder: operand issue, result capture and Des_* register port master.
module adder_host_master
    import adder_host_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_LATENCY = 1
)
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [OPERAND_W-1:0]  op_a,
    input  logic [OPERAND_W-1:0]  op_b,
    output logic                  res_valid,
    output logic [RESULT_W-1:0]   res_data,
    output logic                  err_stray,
    output logic [PENDING_W-1:0]  pending,
    input  logic                  reg_req,
    input  logic                  reg_wr,
    input  logic [DES_ADDR_W-1:0] reg_addr,
    input  logic [OPERAND_W-1:0]  reg_wdata,
    output logic                  reg_busy,
    output logic                  reg_done,
    output logic [OPERAND_W-1:0]  reg_rdata,
    output logic [OPERAND_W-1:0]  Value_a,
    output logic [OPERAND_W-1:0]  Value_b,
    output logic                  Data_val,
    input  logic [OPERAND_W-1:0]  Sum_result,
    input  logic                  Sum_carry,
    input  logic                  Data_ready,
    output logic [DES_ADDR_W-1:0] Des_address,
    output logic [OPERAND_W-1:0]  Des_value,
    output logic                  Des_req_valid,
    output logic                  Des_wr_rd,
    input  logic [OPERAND_W-1:0]  Des_rd_value
);

    reg_state_e        state;
    logic [LAT_W-1:0]  wait_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    op_pair_t          fifo_head;
    op_pair_t          push_pair;
    logic              issue_c;

    assign push_pair = '{a: op_a, b: op_b};
    assign op_ready  = !fifo_full;

    // Register requests in IDLE take precedence over operand issue.
    assign issue_c = !fifo_empty && (state == IDLE) && !reg_req;

    adder_op_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (op_valid),
        .push_data (push_pair),
        .pop       (issue_c),
        .head_c    (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Operand issue, result capture and outstanding-operation tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Value_a   <= '0;
            Value_b   <= '0;
            Data_val  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            pending   <= '0;
            err_stray <= 1'b0;
        end else begin
            Data_val <= issue_c;
            if (issue_c) begin
                Value_a <= fifo_head.a;
                Value_b <= fifo_head.b;
            end
            res_valid <= Data_ready;
            if (Data_ready) res_data <= {Sum_carry, Sum_result};
            if (Data_ready && (pending == '0)) err_stray <= 1'b1;
            case ({issue_c, Data_ready})
                2'b10:   if (pending != '1) pending <= pending + PENDING_W'(1);
                2'b01:   if (pending != '0) pending <= pending - PENDING_W'(1);
                default: ;
            endcase
        end
    end

    // Register transaction FSM driving the Des_* port with registered strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            reg_busy      <= 1'b0;
            reg_done      <= 1'b0;
            reg_rdata     <= '0;
            Des_address   <= '0;
            Des_value     <= '0;
            Des_req_valid <= 1'b0;
            Des_wr_rd     <= 1'b0;
        end else begin
            reg_done      <= 1'b0;
            Des_req_valid <= 1'b0;
            Des_address   <= '0;
            Des_value     <= '0;
            Des_wr_rd     <= 1'b0;
            case (state)
                IDLE: begin
                    if (reg_req) begin
                        state         <= REQ;
                        reg_busy      <= 1'b1;
                        Des_req_valid <= 1'b1;
                        Des_address   <= reg_addr;
                        Des_value     <= (reg_wr == DES_WR) ? reg_wdata : '0;
                        Des_wr_rd     <= reg_wr;
                    end
                end
                REQ: begin
                    if (Des_wr_rd == DES_WR) begin
                        state    <= DONE;
                        reg_done <= 1'b1;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= LAT_W'(RD_LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        reg_rdata <= Des_rd_value;
                        state     <= DONE;
                        reg_done  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - LAT_W'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    reg_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_host_master.sv
// Scoreboard bench for adder_host_master with adder and register-port models.
module tb_adder_host_master;

    localparam int unsigned L = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [7:0] op_a = 8'h00;
    logic [7:0] op_b = 8'h00;
    logic       res_valid;
    logic [8:0] res_data;
    logic       err_stray;
    logic [3:0] pending;
    logic       reg_req = 1'b0;
    logic       reg_wr = 1'b0;
    logic [2:0] reg_addr = 3'd0;
    logic [7:0] reg_wdata = 8'h00;
    logic       reg_busy;
    logic       reg_done;
    logic [7:0] reg_rdata;
    logic [7:0] Value_a;
    logic [7:0] Value_b;
    logic       Data_val;
    logic [7:0] Sum_result = 8'h00;
    logic       Sum_carry = 1'b0;
    logic       Data_ready = 1'b0;
    logic [2:0] Des_address;
    logic [7:0] Des_value;
    logic       Des_req_valid;
    logic       Des_wr_rd;
    logic [7:0] Des_rd_value = 8'hEE;

    adder_host_master #(
        .FIFO_DEPTH (4),
        .RD_LATENCY (L)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .err_stray     (err_stray),
        .pending       (pending),
        .reg_req       (reg_req),
        .reg_wr        (reg_wr),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_busy      (reg_busy),
        .reg_done      (reg_done),
        .reg_rdata     (reg_rdata),
        .Value_a       (Value_a),
        .Value_b       (Value_b),
        .Data_val      (Data_val),
        .Sum_result    (Sum_result),
        .Sum_carry     (Sum_carry),
        .Data_ready    (Data_ready),
        .Des_address   (Des_address),
        .Des_value     (Des_value),
        .Des_req_valid (Des_req_valid),
        .Des_wr_rd     (Des_wr_rd),
        .Des_rd_value  (Des_rd_value)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [15:0] op_q[$];
    logic [8:0]  res_q[$];
    logic [7:0]  regs[8];
    logic [7:0]  exp_regs[8];
    int          last_acc = -100;
    int          acc_gap = 0;
    int          stray_cnt = 0;
    logic [8:0]  stray_val = 9'h000;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Adder model: answers one cycle after each Data_val, or injects a stray answer.
    logic       dv_prev = 1'b0;
    logic [8:0] sum_prev = 9'h000;
    int         stray_seen = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            dv_prev    = 1'b0;
            Data_ready = 1'b0;
        end else begin
            if (stray_cnt != stray_seen) begin
                stray_seen = stray_cnt;
                Data_ready = 1'b1;
                {Sum_carry, Sum_result} = stray_val;
            end else begin
                Data_ready = dv_prev;
                {Sum_carry, Sum_result} = sum_prev;
            end
            dv_prev  = Data_val;
            sum_prev = 9'(Value_a) + 9'(Value_b);
        end
    end

    // Register-port model: read data is only valid in the cycle L after the request.
    int         rd_cnt = 0;
    logic       rd_active = 1'b0;
    logic [2:0] rd_addr = 3'd0;
    always @(negedge clk) begin
        if (!reset_n) begin
            rd_active    = 1'b0;
            rd_cnt       = 0;
            Des_rd_value = 8'hEE;
        end else begin
            if (rd_active) rd_cnt++;
            if (Des_req_valid) begin
                if (Des_wr_rd) begin
                    regs[Des_address] = Des_value;
                end else begin
                    rd_active = 1'b1;
                    rd_cnt    = 0;
                    rd_addr   = Des_address;
                end
            end
            Des_rd_value = (rd_active && rd_cnt == int'(L)) ? regs[rd_addr] : 8'hEE;
            if (rd_cnt >= int'(L)) rd_active = 1'b0;
        end
    end

    // Monitor: checks issued operands, results, pending count and stray flag.
    int          exp_pend = 0;
    logic        exp_err = 1'b0;
    logic        dr_prev = 1'b0;
    logic [15:0] exp_op;
    logic [8:0]  exp_res;
    always begin
        @(negedge clk);
        #1;
        if (!reset_n) begin
            exp_pend = 0;
            exp_err  = 1'b0;
            dr_prev  = 1'b0;
        end else begin
            if (dr_prev && exp_pend == 0) exp_err = 1'b1;
            if (Data_val && !dr_prev && exp_pend < 15) exp_pend++;
            else if (!Data_val && dr_prev && exp_pend > 0) exp_pend--;
            chk("pending", 64'(pending), 64'(exp_pend));
            chk("err_stray", 64'(err_stray), 64'(exp_err));
            if (Data_val) begin
                chk("issue_while_busy", 64'(reg_busy), 64'(0));
                chk("data_val_expected", 64'(op_q.size() != 0), 64'(1));
                if (op_q.size() != 0) begin
                    exp_op = op_q.pop_front();
                    chk("operands", 64'({Value_a, Value_b}), 64'(exp_op));
                end
            end
            if (res_valid) begin
                chk("res_valid_expected", 64'(res_q.size() != 0), 64'(1));
                if (res_q.size() != 0) begin
                    exp_res = res_q.pop_front();
                    chk("res_data", 64'(res_data), 64'(exp_res));
                end
            end
            dr_prev = Data_ready;
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        while (!op_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("push_timeout", 64'(n), 64'(0));
        op_q.push_back({a, b});
        res_q.push_back(9'(a) + 9'(b));
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic reg_txn(input logic wr, input logic [2:0] a, input logic [7:0] d);
        int n = 0;
        while (reg_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("reg_busy_timeout", 64'(n), 64'(0));
        reg_req   = 1'b1;
        reg_wr    = wr;
        reg_addr  = a;
        reg_wdata = d;
        acc_gap   = cyc - last_acc;
        last_acc  = cyc;
        @(negedge clk);
        reg_req = 1'b0;
        chk("des_request", 64'({Des_req_valid, Des_wr_rd, Des_address, Des_value, reg_busy}),
            64'({1'b1, wr, a, (wr ? d : 8'h00), 1'b1}));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!reg_done && n < 40);
        chk("reg_done_latency", 64'(n), 64'(wr ? 1 : int'(L) + 1));
        if (wr) exp_regs[a] = d;
        else    chk("reg_rdata", 64'(reg_rdata), 64'(exp_regs[a]));
    endtask

    task automatic drain();
        int n = 0;
        while ((op_q.size() != 0 || res_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("drain_empty", 64'(op_q.size() + res_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            regs[i]     = 8'($urandom);
            exp_regs[i] = regs[i];
        end
        regs[2]     = 8'h3C;
        exp_regs[2] = 8'h3C;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs",
            64'({op_ready, res_valid, res_data, err_stray, pending, reg_busy, reg_done, reg_rdata,
                 Value_a, Value_b, Data_val, Des_address, Des_value, Des_req_valid, Des_wr_rd}),
            64'({1'b1, 55'd0}));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single operation, then four back-to-back operations.
        push(8'hA1, 8'hC2);
        drain();
        push(8'hD1, 8'h35);
        push(8'h05, 8'h38);
        push(8'h55, 8'h38);
        push(8'hAA, 8'hAA);
        drain();

        // Long read with the FIFO filling behind it.
        fork
            reg_txn(1'b0, 3'd2, 8'h00);
            begin
                repeat (4) push(8'($urandom), 8'($urandom));
                chk("op_ready_full", 64'(op_ready), 64'(0));
                push(8'($urandom), 8'($urandom));
            end
        join
        drain();

        // Back-to-back writes and the readback.
        reg_txn(1'b1, 3'd3, 8'h5A);
        reg_txn(1'b1, 3'd5, 8'h11);
        chk("write_turnaround", 64'(acc_gap), 64'(3));
        reg_txn(1'b0, 3'd3, 8'h00);

        // Stray Data_ready with nothing outstanding.
        repeat (2) @(negedge clk);
        #2;
        stray_val = 9'h1A5;
        res_q.push_back(stray_val);
        stray_cnt++;
        repeat (4) @(negedge clk);
        push(8'h12, 8'h34);
        drain();
        chk("err_stray_sticky", 64'(err_stray), 64'(1));

        // Randomized mix of operands and register transactions.
        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) push(8'($urandom), 8'($urandom));
            else if (r < 8) reg_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
            else repeat (int'($urandom_range(1, 3))) @(negedge clk);
        end
        drain();

        // Reset during WAIT with two queued operands.
        reg_req  = 1'b1;
        reg_wr   = 1'b0;
        reg_addr = 3'd1;
        push(8'h11, 8'h22);
        reg_req = 1'b0;
        push(8'h33, 8'h44);
        op_q.delete();
        res_q.delete();
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_mid_txn",
            64'({op_ready, res_valid, res_data, err_stray, pending, reg_busy, reg_done, reg_rdata,
                 Value_a, Value_b, Data_val, Des_address, Des_value, Des_req_valid, Des_wr_rd}),
            64'({1'b1, 55'd0}));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_reset_quiet", 64'({reg_done, Data_val, reg_busy}), 64'(0));
        end
        push(8'hF0, 8'h0F);
        drain();
        reg_txn(1'b0, 3'd2, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
